// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch definitions: opcodes, special instruction words, fetch states, default widths.
package legv8_pkg;

    localparam int ANCHO_PC_DEF    = 64;
    localparam int ANCHO_INSTR_DEF = 32;

    localparam logic [5:0]  OP_B       = 6'b000101;
    localparam logic [31:0] INSTR_ZERO = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP  = 32'hD503_201F;

    typedef enum logic {
        CORRIENDO = 1'b0,
        PARADO    = 1'b1
    } estado_t;

endpackage

// File: rtl/calc_siguiente_pc.sv
// Next-PC selection for fetch: PC+4, predecoded B target, or masked branch redirect.
// The B predecode path exists only when PREDECODE_B_EN is defined.
module calc_siguiente_pc
    import legv8_pkg::*;
#(
    parameter int ANCHO_PC    = ANCHO_PC_DEF,
    parameter int ANCHO_INSTR = ANCHO_INSTR_DEF
) (
    input  logic [ANCHO_PC-1:0]    pc,
    input  logic [ANCHO_INSTR-1:0] instr,
    input  logic                   salto_tomado,
    input  logic [ANCHO_PC-1:0]    salto_destino,
    output logic [ANCHO_PC-1:0]    pc_siguiente,
    output logic                   es_b,
    output logic                   err_alin
);

`ifdef PREDECODE_B_EN
    localparam bit B_EN = 1'b1;
`else
    localparam bit B_EN = 1'b0;
`endif

    logic signed [ANCHO_PC-1:0] desp_b;
    logic        [ANCHO_PC-1:0] pc_mas4;
    logic        [ANCHO_PC-1:0] pc_normal;

    // imm26 is a word offset: sign-extend and scale by 4 in one concatenation
    assign desp_b    = $signed({{(ANCHO_PC-28){instr[25]}}, instr[25:0], 2'b00});
    assign es_b      = B_EN && (instr[31:26] == OP_B);
    assign pc_mas4   = pc + ANCHO_PC'(4);
    assign pc_normal = es_b ? pc + $unsigned(desp_b) : pc_mas4;

    assign pc_siguiente = salto_tomado ? {salto_destino[ANCHO_PC-1:2], 2'b00} : pc_normal;
    assign err_alin     = salto_tomado && (salto_destino[1:0] != 2'b00);

endmodule

// File: rtl/fetch_pc.sv
// LEGv8 instruction-fetch stage: PC register, IF/ID register, halt-on-zero FSM.
// Optional B predecode in fetch is enabled by defining PREDECODE_B_EN.
module fetch_pc
    import legv8_pkg::*;
#(
    parameter int                ANCHO_PC    = ANCHO_PC_DEF,
    parameter int                ANCHO_INSTR = ANCHO_INSTR_DEF,
    parameter logic [ANCHO_PC-1:0] PC_RESET  = '0,
    parameter bit                PARAR_CERO  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ANCHO_PC-1:0]    bus_pc,
    input  logic [ANCHO_INSTR-1:0] bus_instruccion,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   salto_tomado,
    input  logic [ANCHO_PC-1:0]    salto_destino,
    output logic [ANCHO_PC-1:0]    if_id_pc,
    output logic [ANCHO_INSTR-1:0] if_id_instr,
    output logic                   if_id_valido,
    output logic                   if_id_pred,
    output logic                   err_alin
);

    estado_t               estado;
    logic [ANCHO_PC-1:0]   pc_p0;
    logic [ANCHO_PC-1:0]   pc_siguiente;
    logic                  es_b;
    logic                  err_alin_d;

    assign bus_pc = pc_p0;

    calc_siguiente_pc #(
        .ANCHO_PC    (ANCHO_PC),
        .ANCHO_INSTR (ANCHO_INSTR)
    ) u_calc (
        .pc            (pc_p0),
        .instr         (bus_instruccion),
        .salto_tomado  (salto_tomado),
        .salto_destino (salto_destino),
        .pc_siguiente  (pc_siguiente),
        .es_b          (es_b),
        .err_alin      (err_alin_d)
    );

    // Fetch -> IF/ID boundary; priority: redirect > halted > stall > zero-word halt > fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado       <= CORRIENDO;
            pc_p0        <= PC_RESET;
            if_id_pc     <= '0;
            if_id_instr  <= '0;
            if_id_valido <= 1'b0;
            if_id_pred   <= 1'b0;
            err_alin     <= 1'b0;
        end else begin
            err_alin <= err_alin_d;
            if (salto_tomado) begin
                estado       <= CORRIENDO;
                pc_p0        <= pc_siguiente;
                if_id_valido <= 1'b0;
                if_id_pred   <= 1'b0;
            end else if (estado == PARADO) begin
                if_id_valido <= 1'b0;
            end else if (stall) begin
                if (flush)
                    if_id_valido <= 1'b0;
            end else if (PARAR_CERO && (bus_instruccion == ANCHO_INSTR'(INSTR_ZERO))) begin
                estado       <= PARADO;
                if_id_valido <= 1'b0;
                if_id_pred   <= 1'b0;
            end else begin
                pc_p0        <= pc_siguiente;
                if_id_pc     <= pc_p0;
                if_id_instr  <= bus_instruccion;
                if_id_valido <= !flush;
                if_id_pred   <= es_b && !flush;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: directed scenarios followed by randomized control traffic.
module tb_fetch_pc;

`ifdef PREDECODE_B_EN
    localparam bit B_EN = 1'b1;
`else
    localparam bit B_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        stall;
    logic        flush;
    logic        salto_tomado;
    logic [63:0] salto_destino;
    logic [31:0] bus_instruccion;
    logic [63:0] bus_pc;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valido;
    logic        if_id_pred;
    logic        err_alin;

    logic [31:0] mem [0:511];
    assign bus_instruccion = mem[bus_pc[10:2]];

    fetch_pc dut (
        .clk             (clk),
        .reset           (reset),
        .bus_pc          (bus_pc),
        .bus_instruccion (bus_instruccion),
        .stall           (stall),
        .flush           (flush),
        .salto_tomado    (salto_tomado),
        .salto_destino   (salto_destino),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr),
        .if_id_valido    (if_id_valido),
        .if_id_pred      (if_id_pred),
        .err_alin        (err_alin)
    );

    // Second instance starting at the top of the address space
    logic [31:0] w_instr = 32'hF840_02A0;
    logic        w_cero  = 1'b0;
    logic [63:0] w_dest  = 64'h0;
    logic [63:0] w_bus_pc;
    logic [63:0] w_if_pc;
    logic [31:0] w_if_instr;
    logic        w_valido;
    logic        w_pred;
    logic        w_err;

    fetch_pc #(.PC_RESET(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
        .clk             (clk),
        .reset           (reset),
        .bus_pc          (w_bus_pc),
        .bus_instruccion (w_instr),
        .stall           (w_cero),
        .flush           (w_cero),
        .salto_tomado    (w_cero),
        .salto_destino   (w_dest),
        .if_id_pc        (w_if_pc),
        .if_id_instr     (w_if_instr),
        .if_id_valido    (w_valido),
        .if_id_pred      (w_pred),
        .err_alin        (w_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] m_pc;
    logic [63:0] m_ifpc;
    logic [31:0] m_ifins;
    logic        m_vld;
    logic        m_pred;
    logic        m_err;
    logic        m_halt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 64'h0; m_ifpc = 64'h0; m_ifins = 32'h0;
        m_vld = 1'b0; m_pred = 1'b0; m_err = 1'b0; m_halt = 1'b0;
    endtask

    task automatic compare_all();
        chk("bus_pc", bus_pc, m_pc);
        chk("if_id_pc", if_id_pc, m_ifpc);
        chk("if_id_instr", {32'h0, if_id_instr}, {32'h0, m_ifins});
        chk("if_id_valido", {63'h0, if_id_valido}, {63'h0, m_vld});
        chk("if_id_pred", {63'h0, if_id_pred}, {63'h0, m_pred});
        chk("err_alin", {63'h0, err_alin}, {63'h0, m_err});
    endtask

    // One clock of the fetch rules applied to the model, then compare after the edge
    task automatic step();
        logic [31:0] w;
        logic [63:0] off;
        logic        b;
        w     = mem[m_pc[10:2]];
        m_err = 1'b0;
        if (salto_tomado) begin
            m_err  = (salto_destino[1:0] != 2'b00);
            m_pc   = salto_destino & ~64'h3;
            m_vld  = 1'b0;
            m_pred = 1'b0;
            m_halt = 1'b0;
        end else if (m_halt) begin
            m_vld = 1'b0;
        end else if (stall) begin
            if (flush) m_vld = 1'b0;
        end else if (w == 32'h0) begin
            m_halt = 1'b1;
            m_vld  = 1'b0;
            m_pred = 1'b0;
        end else begin
            b       = B_EN && (w[31:26] == 6'b000101);
            off     = {{36{w[25]}}, w[25:0], 2'b00};
            m_ifpc  = m_pc;
            m_ifins = w;
            m_vld   = !flush;
            m_pred  = b && !flush;
            m_pc    = b ? m_pc + off : m_pc + 64'd4;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        salto_tomado = 1'b0; salto_destino = 64'h0;
        for (int i = 0; i < 512; i++) mem[i] = 32'hF840_0000 | i;
        mem[0]  = 32'hF840_02A0;
        mem[1]  = 32'hF840_02A1;
        mem[7]  = 32'h17FF_FFFC;
        mem[10] = 32'h0000_0000;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("reset_bus_pc", bus_pc, 64'h0);
        chk("reset_w_bus_pc", w_bus_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        reset = 1'b0;

        step();
        chk("e1_ifpc", if_id_pc, 64'h0);
        chk("e1_bus_pc", bus_pc, 64'h4);
        chk("wrap_bus_pc", w_bus_pc, 64'h0);
        chk("wrap_ifpc", w_if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("e2_ifins", {32'h0, if_id_instr}, 64'hF840_02A1);
        chk("e2_bus_pc", bus_pc, 64'h8);

        stall = 1'b1;
        repeat (3) step();
        chk("stall_bus_pc", bus_pc, 64'h8);
        chk("stall_ifpc", if_id_pc, 64'h4);
        stall = 1'b0;
        step();
        chk("resume_ifpc", if_id_pc, 64'h8);

        stall = 1'b1; salto_tomado = 1'b1; salto_destino = 64'h0E;
        step();
        chk("redir_bus_pc", bus_pc, 64'h0C);
        chk("redir_err", {63'h0, err_alin}, 64'h1);
        stall = 1'b0; salto_tomado = 1'b0;
        step();
        chk("err_pulse_end", {63'h0, err_alin}, 64'h0);
        repeat (3) step();
        chk("at_1c", bus_pc, 64'h1C);
        step();
        chk("b_next_pc", bus_pc, B_EN ? 64'h0C : 64'h20);
        chk("b_pred", {63'h0, if_id_pred}, {63'h0, B_EN});

        salto_tomado = 1'b1; salto_destino = 64'h20;
        step();
        salto_tomado = 1'b0;
        repeat (2) step();
        chk("at_28", bus_pc, 64'h28);
        repeat (3) step();
        chk("halt_bus_pc", bus_pc, 64'h28);
        chk("halt_valid", {63'h0, if_id_valido}, 64'h0);
        salto_tomado = 1'b1; salto_destino = 64'h0C;
        step();
        salto_tomado = 1'b0;
        step();
        chk("restart_ifpc", if_id_pc, 64'h0C);
        chk("restart_valid", {63'h0, if_id_valido}, 64'h1);

        flush = 1'b1;
        step();
        chk("flush_valid", {63'h0, if_id_valido}, 64'h0);
        chk("flush_bus_pc", bus_pc, 64'h14);
        flush = 1'b0;

        for (int i = 0; i < 512; i++)
            if ($urandom_range(15) == 0) mem[i] = 32'h0;
            else mem[i] = $urandom;
        for (int k = 0; k < 400; k++) begin
            stall         = ($urandom_range(3) == 0);
            flush         = ($urandom_range(4) == 0);
            salto_tomado  = ($urandom_range(7) == 0);
            salto_destino = {$urandom, $urandom};
            step();
        end
        stall = 1'b0; flush = 1'b0; salto_tomado = 1'b0;
        step();

        stall = 1'b1;
        repeat (2) step();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("async_bus_pc", bus_pc, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0; stall = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
